bus_interconnect: RTL and testbench
===================================

// Module: bus_interconnect
// PURPOSE
// Parametrised single-master, N-slave bus interconnect replacing hand-coded bank decode in SoC tops.
// Decodes address bits [31:24] against a per-slave bank map and forwards strobes to the selected slave.
// Returns ack plus read data, byte-lane masked, to the CPU.
// Adds a registered response path, a per-access ack timeout, error signalling for unmapped/hung banks, and an error counter.
// PARAMETERS
// N_SLAVES    4           number of slave ports (1..16)
// BANK_MAP    {8'h03,8'h02,8'h01,8'h00}  N_SLAVES*8 bits; byte k = bank served by slave k
// TIMEOUT     255         cycles in ACTIVE without slave ack before error (1..65535)
// CNT_W       16          width of error counter
// PORTS
// clk          in   1            system clock
// rst_i        in   1            reset, asynchronous, active-high
// m_stb_i      in   1            master strobe; held high until m_ack_o or m_err_o
// m_we_i       in   1            master write enable
// m_adr_i      in   32           master address; [31:24] = bank
// m_dat_i      in   32           master write data
// m_sel_i      in   4            master byte lane select
// m_dat_o      out  32           read data, registered
// m_ack_o      out  1            access complete, one-cycle pulse
// m_err_o      out  1            access failed (unmapped/timeout), one-cycle pulse
// s_stb_o      out  N_SLAVES     per-slave strobe, one-hot or zero
// s_we_o       out  1            = m_we_i
// s_adr_o      out  32           = m_adr_i
// s_dat_o      out  32           = m_dat_i
// s_sel_o      out  4            = m_sel_i
// s_ack_i      in   N_SLAVES     per-slave ack
// s_dat_i      in   N_SLAVES*32  per-slave read data, slave k at [32k+31:32k]
// err_cnt_o    out  CNT_W        number of error terminations since reset, saturating
// err_adr_o    out  32           address of most recent erroring access
// BEHAVIOUR
// - Reset (async): state IDLE; s_stb_o, m_ack_o, m_err_o = 0; m_dat_o, err_cnt_o, err_adr_o = 0; timer = 0.
// - FSM IDLE -> ACTIVE | RESP; ACTIVE -> RESP | IDLE; RESP -> IDLE.
// - IDLE: on m_stb_i, decode bank against BANK_MAP.
//   - Match: latch slave index, go ACTIVE.
//   - No match: go RESP with err flag.
//   - Multiple matches: lowest index wins.
// - ACTIVE: s_stb_o[idx] = 1 (registered, from first ACTIVE cycle); timer increments each cycle.
//   - s_ack_i[idx] = 1: latch s_dat_i[idx] into m_dat_o, lanes with m_sel_i[b]=0 forced to 8'h00 (writes: m_dat_o unchanged); go RESP ok.
//   - Acks from non-selected slaves are ignored.
//   - timer == TIMEOUT with no ack: go RESP with err flag; s_stb_o drops.
//   - m_stb_i low (master abort): s_stb_o drops next cycle, go IDLE, no ack/err, no count.
// - RESP: exactly one of m_ack_o/m_err_o high for one cycle; s_stb_o = 0; next cycle IDLE.
//   - On err: m_dat_o = 0, err_adr_o = m_adr_i, err_cnt_o += 1, saturating at all-ones.
// - Latency: slave acking on first strobe cycle -> m_ack_o 3 cycles after m_stb_i rises (IDLE, ACTIVE, RESP).
//   Unmapped bank -> m_err_o 2 cycles after m_stb_i rises.
// - Master must drop m_stb_i the cycle after ack/err; a still-high stb in IDLE starts a new access (back-to-back allowed).
// - Timer resets to 0 on every entry to ACTIVE; timer width = clog2(TIMEOUT+1).
// - s_we_o/s_adr_o/s_dat_o/s_sel_o are combinational pass-throughs; slaves qualify them with s_stb_o.
// - rst_i mid-access: s_stb_o clears immediately (async); in-flight access discarded; no ack/err emitted.
// TESTING
// - Read bank 8'h02, slave 2 acks on 2nd strobe cycle with 32'hDEADBEEF, sel=4'b1111 -> m_ack_o 4 cycles after stb, m_dat_o=32'hDEADBEEF.
// - Read bank 8'h00, sel=4'b0011, slave data 32'h12345678 -> m_dat_o=32'h00005678.
// - Access to bank 8'h7F -> m_err_o 2 cycles after stb, err_cnt_o=1, err_adr_o=m_adr_i, no s_stb_o pulse.
// - TIMEOUT=8, slave 1 never acks -> s_stb_o[1] high 9 cycles, then m_err_o pulse, err_cnt_o increments.
// - Write to bank 8'h01 while slave 3 asserts spurious ack -> only s_ack_i[1] completes; m_ack_o single pulse.
// - Assert rst_i during ACTIVE -> s_stb_o=0 same cycle; after release, new access completes normally.

Source files
------------

// File: rtl/bus_interconnect.sv
// Single-master, N-slave bus interconnect: bank decode on address[31:24], strobe forwarding,
// registered response path with ack timeout, error signalling and a saturating error counter.
module bus_interconnect #(
    parameter int unsigned             N_SLAVES = 4,
    parameter logic [N_SLAVES*8-1:0]   BANK_MAP = {8'h03, 8'h02, 8'h01, 8'h00},
    parameter int unsigned             TIMEOUT  = 255,
    parameter int unsigned             CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   m_stb_i,
    input  logic                   m_we_i,
    input  logic [31:0]            m_adr_i,
    input  logic [31:0]            m_dat_i,
    input  logic [3:0]             m_sel_i,
    output logic [31:0]            m_dat_o,
    output logic                   m_ack_o,
    output logic                   m_err_o,
    output logic [N_SLAVES-1:0]    s_stb_o,
    output logic                   s_we_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic [3:0]             s_sel_o,
    input  logic [N_SLAVES-1:0]    s_ack_i,
    input  logic [N_SLAVES*32-1:0] s_dat_i,
    output logic [CNT_W-1:0]       err_cnt_o,
    output logic [31:0]            err_adr_o
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [N_SLAVES-1:0] stb_d;
    logic                ack_d, err_d;
    logic [31:0]         dat_d, eadr_d;
    logic [CNT_W-1:0]    cnt_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                sel_ack;
    logic [31:0]         sel_dat;
    logic [31:0]         masked_dat;
    logic                fail;

    // Slaves see the master request directly and qualify it with their own strobe.
    assign s_we_o  = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    // Bank decode; scanning downwards lets the lowest matching slave index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = int'(N_SLAVES) - 1; k >= 0; k--) begin
            if (BANK_MAP[8*k +: 8] == m_adr_i[31:24]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // Response mux for the latched slave; acks from other slaves never reach the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[32*k +: 32];
            end
        end
        for (int b = 0; b < 4; b++) begin
            masked_dat[8*b +: 8] = m_sel_i[b] ? sel_dat[8*b +: 8] : 8'h00;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        stb_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = m_dat_o;
        eadr_d  = err_adr_o;
        cnt_d   = err_cnt_o;
        fail    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_stb_i) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        timer_d = '0;
                        stb_d   = N_SLAVES'(1) << hit_idx;
                        state_d = ST_ACTIVE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_stb_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    dat_d   = m_we_i ? m_dat_o : masked_dat;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    stb_d   = N_SLAVES'(1) << idx_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Unmapped bank or hung slave: terminate with an error response.
        if (fail) begin
            err_d   = 1'b1;
            dat_d   = '0;
            eadr_d  = m_adr_i;
            cnt_d   = (&err_cnt_o) ? err_cnt_o : err_cnt_o + CNT_W'(1);
            state_d = ST_RESP;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            s_stb_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_dat_o   <= '0;
            err_adr_o <= '0;
            err_cnt_o <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            s_stb_o   <= stb_d;
            m_ack_o   <= ack_d;
            m_err_o   <= err_d;
            m_dat_o   <= dat_d;
            err_adr_o <= eadr_d;
            err_cnt_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Testbench for bus_interconnect: directed scenarios plus randomized accesses checked
// against a transaction-level model of decode, slave latency, timeout and error bookkeeping.
module tb_bus_interconnect;

    localparam int TMO = 8;
    localparam int CW  = 4;

    logic         clk;
    logic         rst_i;
    logic         m_stb_i, m_we_i;
    logic [31:0]  m_adr_i, m_dat_i;
    logic [3:0]   m_sel_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o, m_err_o;
    logic [3:0]   s_stb_o;
    logic         s_we_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic [3:0]   s_ack_i;
    logic [127:0] s_dat_i;
    logic [CW-1:0] err_cnt_o;
    logic [31:0]  err_adr_o;

    bus_interconnect #(
        .N_SLAVES (4),
        .BANK_MAP ({8'h03, 8'h02, 8'h01, 8'h00}),
        .TIMEOUT  (TMO),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .err_cnt_o (err_cnt_o),
        .err_adr_o (err_adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave models: slave k acks on its delay[k]-th strobe cycle (0 = never); spur adds stray acks.
    int          delay   [4];
    logic [31:0] slv_dat [4];
    logic [3:0]  spur;
    int          scnt    [4];
    logic [3:0]  ackv;

    always_comb begin
        for (int k = 0; k < 4; k++) s_dat_i[32*k +: 32] = slv_dat[k];
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            scnt[k] = s_stb_o[k] ? scnt[k] + 1 : 0;
            ackv[k] = s_stb_o[k] && (delay[k] != 0) && (scnt[k] == delay[k]);
        end
        s_ack_i = ackv | spur;
    end

    // Reference state: bank map and expected sticky outputs.
    int          bank_of [4] = '{0, 1, 2, 3};
    logic [31:0] exp_dat;
    int          exp_cnt;
    logic [31:0] exp_eadr;

    // Latencies are in clock edges after the strobe is raised (cycle count minus one).
    task automatic predict(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input bit b2b, output bit e_ack, output int e_lat,
                           output int e_stbc, output logic [3:0] e_stbm);
        int k = -1;
        for (int j = 3; j >= 0; j--) if (bank_of[j] == int'(adr[31:24])) k = j;
        e_ack = 1'b0; e_stbc = 0; e_stbm = 4'b0000; e_lat = 1;
        if (k >= 0) begin
            e_stbm = 4'b0001 << k;
            if (delay[k] >= 1 && delay[k] <= TMO + 1) begin
                e_ack = 1'b1; e_lat = delay[k] + 1; e_stbc = delay[k];
                if (!we) exp_dat = slv_dat[k] & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            end else begin
                e_lat = TMO + 2; e_stbc = TMO + 1;
            end
        end
        if (!e_ack) begin
            exp_dat = 32'h0; exp_eadr = adr;
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        if (b2b) e_lat++;
    endtask

    // Drives one access and records what the master side observed; hold keeps stb high afterwards.
    task automatic do_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit hold, output int lat, output int stbc,
                             output logic [3:0] stbm, output bit got_ack, output bit got_err,
                             output bit pulse_ok);
        int i = 0;
        lat = 0; stbc = 0; stbm = 4'b0000; got_ack = 1'b0; got_err = 1'b0; pulse_ok = 1'b1;
        if (!m_stb_i) @(negedge clk);
        m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = sel; m_stb_i = 1'b1;
        while (i < 60 && !(got_ack || got_err)) begin
            i++;
            @(posedge clk); #1;
            if (s_stb_o != 4'b0000) stbc++;
            stbm |= s_stb_o;
            if (m_ack_o || m_err_o) begin
                lat = i; got_ack = m_ack_o; got_err = m_err_o;
            end
        end
        if (!hold || lat == 0) m_stb_i = 1'b0;
        if (!hold && lat != 0) begin
            @(posedge clk); #1;
            pulse_ok = !m_ack_o && !m_err_o;
        end
    endtask

    bit e_ack, g_ack, g_err, p_ok;
    int e_lat, e_stbc, lat, stbc;
    logic [3:0] e_stbm, stbm;

    task automatic test_reset();
        rst_i = 1'b1; m_stb_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        spur = 4'b0000;
        for (int k = 0; k < 4; k++) begin delay[k] = 1; slv_dat[k] = '0; scnt[k] = 0; end
        exp_dat = '0; exp_cnt = 0; exp_eadr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_stb_o, m_ack_o, m_err_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 0", {s_stb_o, m_ack_o, m_err_o});
        end
        n_checks++;
        if ({m_dat_o, err_adr_o, err_cnt_o} !== '0) begin
            n_fail++; $display("FAIL reset_regs: got %h/%h/%0d required 0", m_dat_o, err_adr_o, err_cnt_o);
        end
        @(negedge clk) rst_i = 1'b0;
    endtask

    task automatic test_read_full();
        delay[2] = 2; slv_dat[2] = 32'hDEADBEEF;
        predict(1'b0, 32'h0200_0010, 4'hF, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0200_0010, 32'h0, 4'hF, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (!(g_ack && !g_err) || lat + 1 != 4) begin
            n_fail++; $display("FAIL read_full_ack: ack=%0b err=%0b cycles=%0d required ack in 4", g_ack, g_err, lat + 1);
        end
        n_checks++;
        if (m_dat_o !== 32'hDEADBEEF || stbm !== 4'b0100) begin
            n_fail++; $display("FAIL read_full_data: got %h stb %b required deadbeef stb 0100", m_dat_o, stbm);
        end
    endtask

    task automatic test_lane_mask();
        delay[0] = 1; slv_dat[0] = 32'h12345678;
        predict(1'b0, 32'h0000_0004, 4'b0011, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0000_0004, 32'h0, 4'b0011, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (m_dat_o !== 32'h0000_5678 || lat + 1 != 3 || !g_ack) begin
            n_fail++; $display("FAIL lane_mask: got %h in %0d cycles required 00005678 in 3", m_dat_o, lat + 1);
        end
    endtask

    task automatic test_unmapped();
        predict(1'b0, 32'h7F00_1234, 4'hF, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h7F00_1234, 32'h0, 4'hF, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (!g_err || g_ack || lat + 1 != 2 || stbm !== 4'b0000) begin
            n_fail++; $display("FAIL unmapped_err: err=%0b cycles=%0d stb=%b required err in 2, no stb", g_err, lat + 1, stbm);
        end
        n_checks++;
        if (err_cnt_o !== CW'(1) || err_adr_o !== 32'h7F00_1234 || m_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_log: cnt=%0d adr=%h dat=%h required 1/7f001234/0", err_cnt_o, err_adr_o, m_dat_o);
        end
    endtask

    task automatic test_timeout();
        delay[1] = 0;
        predict(1'b0, 32'h0100_0020, 4'hF, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0100_0020, 32'h0, 4'hF, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (stbc != 9 || stbm !== 4'b0010) begin
            n_fail++; $display("FAIL timeout_strobe: got %0d cycles on %b required 9 on 0010", stbc, stbm);
        end
        n_checks++;
        if (!g_err || g_ack || err_cnt_o !== CW'(2) || !p_ok) begin
            n_fail++; $display("FAIL timeout_err: err=%0b cnt=%0d pulse=%0b required 1/2/1", g_err, err_cnt_o, p_ok);
        end
    endtask

    task automatic test_spurious_write();
        delay[1] = 2; delay[3] = 0; spur = 4'b1000;
        predict(1'b1, 32'h0100_0040, 4'b1010, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b1, 32'h0100_0040, 32'hAABBCCDD, 4'b1010, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        spur = 4'b0000;
        n_checks++;
        if (!g_ack || g_err || !p_ok || lat != e_lat || stbm !== 4'b0010) begin
            n_fail++; $display("FAIL spurious_write: ack=%0b pulse=%0b lat=%0d stb=%b required 1/1/%0d/0010", g_ack, p_ok, lat, stbm, e_lat);
        end
        n_checks++;
        if (m_dat_o !== exp_dat) begin
            n_fail++; $display("FAIL write_keeps_dat: got %h required %h", m_dat_o, exp_dat);
        end
        n_checks++;
        if ({s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {1'b1, 32'h0100_0040, 32'hAABBCCDD, 4'b1010}) begin
            n_fail++; $display("FAIL passthrough: got %b %h %h %b", s_we_o, s_adr_o, s_dat_o, s_sel_o);
        end
    endtask

    task automatic test_back_to_back();
        delay[3] = 1; slv_dat[3] = 32'hCAFE_F00D; delay[2] = 1; slv_dat[2] = 32'h0BAD_BEEF;
        predict(1'b0, 32'h0300_0000, 4'hF, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0300_0000, 32'h0, 4'hF, 1'b1, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (!g_ack || m_dat_o !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL b2b_first: ack=%0b dat=%h required 1/cafef00d", g_ack, m_dat_o);
        end
        predict(1'b0, 32'h0200_0000, 4'b1100, 1'b1, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0200_0000, 32'h0, 4'b1100, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (!g_ack || lat != e_lat || m_dat_o !== 32'h0BAD_0000 || !p_ok) begin
            n_fail++; $display("FAIL b2b_second: lat=%0d dat=%h required %0d/0bad0000", lat, m_dat_o, e_lat);
        end
    endtask

    task automatic test_random();
        bit b2b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] adr;
            logic [3:0]  sel;
            logic        we;
            bit          hold;
            int          bsel;
            bsel = $urandom_range(0, 4);
            adr  = $urandom;
            if (bsel < 4) adr[31:24] = 8'(bsel);
            sel  = 4'($urandom);
            we   = 1'($urandom);
            hold = (n != 39) && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                delay[k]   = $urandom_range(0, TMO + 3);
                slv_dat[k] = $urandom;
            end
            spur = 4'($urandom) & ~(bsel < 4 ? 4'(4'b0001 << bsel) : 4'b0000);
            predict(we, adr, sel, b2b, e_ack, e_lat, e_stbc, e_stbm);
            do_access(we, adr, $urandom, sel, hold, lat, stbc, stbm, g_ack, g_err, p_ok);
            n_checks++;
            if (g_ack !== e_ack || g_err !== !e_ack || lat != e_lat) begin
                n_fail++; $display("FAIL rand_resp[%0d]: ack=%0b err=%0b lat=%0d required ack=%0b lat=%0d", n, g_ack, g_err, lat, e_ack, e_lat);
            end
            n_checks++;
            if (stbc != e_stbc || stbm !== e_stbm || !p_ok) begin
                n_fail++; $display("FAIL rand_strobe[%0d]: cycles=%0d mask=%b pulse=%0b required %0d/%b/1", n, stbc, stbm, p_ok, e_stbc, e_stbm);
            end
            n_checks++;
            if (m_dat_o !== exp_dat || err_cnt_o !== CW'(exp_cnt) || err_adr_o !== exp_eadr) begin
                n_fail++; $display("FAIL rand_regs[%0d]: dat=%h cnt=%0d eadr=%h required %h/%0d/%h", n, m_dat_o, err_cnt_o, err_adr_o, exp_dat, exp_cnt, exp_eadr);
            end
            b2b = hold;
        end
        spur = 4'b0000;
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 18; n++) begin
            predict(1'b0, {8'hA0 + 8'(n), 24'h00_0BEE}, 4'hF, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
            do_access(1'b0, {8'hA0 + 8'(n), 24'h00_0BEE}, 32'h0, 4'hF, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
            n_checks++;
            if (err_cnt_o !== CW'(exp_cnt) || !g_err || err_adr_o !== exp_eadr) begin
                n_fail++; $display("FAIL saturate[%0d]: cnt=%0d err=%0b required %0d/1", n, err_cnt_o, g_err, exp_cnt);
            end
        end
        n_checks++;
        if (err_cnt_o !== 4'hF) begin
            n_fail++; $display("FAIL saturate_final: got %0d required 15", err_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        delay[1] = 0;
        @(negedge clk);
        m_we_i = 1'b0; m_adr_i = 32'h0100_0000; m_sel_i = 4'hF; m_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_stb_o !== 4'b0010) begin
            n_fail++; $display("FAIL midrst_active: stb=%b required 0010", s_stb_o);
        end
        #2 rst_i = 1'b1;
        #1;
        n_checks++;
        if (s_stb_o !== 4'b0000 || m_ack_o || m_err_o || err_cnt_o !== '0 || m_dat_o !== '0) begin
            n_fail++; $display("FAIL midrst_clear: stb=%b ack=%0b err=%0b cnt=%0d required all 0", s_stb_o, m_ack_o, m_err_o, err_cnt_o);
        end
        m_stb_i = 1'b0;
        @(negedge clk) rst_i = 1'b0;
        exp_dat = '0; exp_cnt = 0; exp_eadr = '0;
        delay[3] = 1; slv_dat[3] = 32'h0F1E_2D3C;
        predict(1'b0, 32'h0300_0100, 4'b0110, 1'b0, e_ack, e_lat, e_stbc, e_stbm);
        do_access(1'b0, 32'h0300_0100, 32'h0, 4'b0110, 1'b0, lat, stbc, stbm, g_ack, g_err, p_ok);
        n_checks++;
        if (!g_ack || lat != e_lat || m_dat_o !== 32'h001E_2D00 || err_cnt_o !== '0) begin
            n_fail++; $display("FAIL midrst_after: ack=%0b lat=%0d dat=%h cnt=%0d required 1/%0d/001e2d00/0", g_ack, lat, m_dat_o, err_cnt_o, e_lat);
        end
    endtask

    initial begin
        test_reset();
        test_read_full();
        test_lane_mask();
        test_unmapped();
        test_timeout();
        test_spurious_write();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
